// File: rtl/ventana_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ventana_pkg
// Brief    : Shared defaults, FSM state and window type for ventana_laplace.
// Revision : 1.0 - initial release
// ============================================================================
package ventana_pkg;

    localparam int COLS_DEF  = 512;
    localparam int ROWS_DEF  = 512;
    localparam int PIX_W_DEF = 8;

    typedef enum logic [0:0] {
        LLENANDO   = 1'b0,
        PROCESANDO = 1'b1
    } estado_t;

    typedef struct packed {
        logic [PIX_W_DEF-1:0] b;
        logic [PIX_W_DEF-1:0] d;
        logic [PIX_W_DEF-1:0] e;
        logic [PIX_W_DEF-1:0] f;
        logic [PIX_W_DEF-1:0] h;
    } ventana_t;

endpackage
`default_nettype wire

// File: rtl/linea_buffer.sv
`default_nettype none
// ============================================================================
// Module   : linea_buffer
// Brief    : COLS x PIX_W single-port line RAM, read-before-write, with enable.
// Revision : 1.0 - initial release
// ============================================================================
module linea_buffer
    import ventana_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [$clog2(COLS)-1:0]  i_addr,
    input  logic [PIX_W-1:0]         i_wdata,
    output logic [PIX_W-1:0]         o_rdata
);

    logic [PIX_W-1:0] r_mem [COLS];

    // Asynchronous read returns the old word during the write cycle.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ventana_laplace.sv
`default_nettype none
// ============================================================================
// Module   : ventana_laplace
// Brief    : Raster-order streaming generator of the 5-point cross window.
// Revision : 1.0 - initial release
// ============================================================================
module ventana_laplace
    import ventana_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] h,
    output logic             win_valid,
    output logic             win_last
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] c_col_last = CW'(COLS - 1);
    localparam logic [CW-1:0] c_col_two  = CW'(2);
    localparam logic [CW-1:0] c_col_inc  = CW'(1);
    localparam logic [RW-1:0] c_row_last = RW'(ROWS - 1);
    localparam logic [RW-1:0] c_row_one  = RW'(1);
    localparam logic [RW-1:0] c_row_inc  = RW'(1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    estado_t          r_estado;

    logic [PIX_W-1:0] w_l1;
    logic [PIX_W-1:0] w_l2;
    logic [PIX_W-1:0] r_cur;
    logic [PIX_W-1:0] r_m1_0;
    logic [PIX_W-1:0] r_m1_1;
    logic [PIX_W-1:0] r_m2;

    logic             w_fin_fila;
    logic             w_fin_frame;
    logic             w_emite;

    assign w_fin_fila  = (r_col == c_col_last);
    assign w_fin_frame = w_fin_fila && (r_row == c_row_last);
    assign w_emite     = pix_valid && (r_estado == PROCESANDO) && (r_col >= c_col_two);

    // Buffer 1 holds row r-1, buffer 2 holds row r-2.
    linea_buffer #(
        .COLS  (COLS),
        .PIX_W (PIX_W)
    ) u_buf1 (
        .clk     (clk),
        .i_en    (pix_valid),
        .i_addr  (r_col),
        .i_wdata (pix_in),
        .o_rdata (w_l1)
    );

    linea_buffer #(
        .COLS  (COLS),
        .PIX_W (PIX_W)
    ) u_buf2 (
        .clk     (clk),
        .i_en    (pix_valid),
        .i_addr  (r_col),
        .i_wdata (w_l1),
        .o_rdata (w_l2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_estado  <= LLENANDO;
            r_cur     <= '0;
            r_m1_0    <= '0;
            r_m1_1    <= '0;
            r_m2      <= '0;
            b         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            h         <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= w_emite;
            win_last  <= w_emite && w_fin_frame;

            // Window is centred on (r-1, c-1) of the pixel being accepted.
            if (w_emite) begin
                b <= r_m2;
                d <= r_m1_1;
                e <= r_m1_0;
                f <= w_l1;
                h <= r_cur;
            end

            if (pix_valid) begin
                r_cur  <= pix_in;
                r_m1_0 <= w_l1;
                r_m1_1 <= r_m1_0;
                r_m2   <= w_l2;

                if (w_fin_fila) begin
                    r_col <= '0;
                    r_row <= w_fin_frame ? '0 : (r_row + c_row_inc);
                end else begin
                    r_col <= r_col + c_col_inc;
                end

                if (r_estado == LLENANDO) begin
                    if (w_fin_fila && (r_row == c_row_one)) begin
                        r_estado <= PROCESANDO;
                    end
                end else begin
                    if (w_fin_frame) begin
                        r_estado <= LLENANDO;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ventana_laplace.md
# ventana_laplace

Streaming window generator that sits directly upstream of the combinational 5-point Laplacian filter. It accepts one 8-bit grayscale pixel per clock in raster order and emits the cross-shaped neighbourhood b, d, e, f, h for every interior output position, in raster order. This replaces the bench-side image indexing with synthesizable hardware. Each frame yields (ROWS-2)*(COLS-2) windows, 260100 for 512×512.

## Interface
- COLS, 512, pixels per image row (≥3)
- ROWS, 512, rows per frame (≥3)
- PIX_W, 8, pixel width in bits
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pix_in  in  PIX_W  input pixel, raster order
- pix_valid  in  1  pix_in accepted on this edge when high; no backpressure
- b  out  PIX_W  pixel above centre
- d  out  PIX_W  pixel left of centre
- e  out  PIX_W  centre pixel
- f  out  PIX_W  pixel right of centre
- h  out  PIX_W  pixel below centre
- win_valid  out  1  b..h hold a valid window this cycle
- win_last  out  1  high with the final window of the frame

## Operation
- Counters col (0..COLS-1) and row (0..ROWS-1) track the coordinates of the pixel being accepted. They advance only on pix_valid.
- col wraps to 0 at COLS-1 and row increments. At (ROWS-1, COLS-1), both wrap to 0 and the next accepted pixel begins a new frame.
- Two line buffers, each COLS×PIX_W and addressed by col, hold rows r-1 and r-2.
  - On accept, each buffer is read before it is written.
  - Buffer 1 is written with pix_in. Buffer 2 is written with buffer 1's old value.
- Shift registers:
  - Current row: 1-deep, giving p[r][c-1].
  - Row r-1: 2-deep, giving p[r-1][c-1] and p[r-1][c-2].
  - Row r-2: 1-deep, giving p[r-2][c-1].
- Window emitted on accepting pixel (r,c):
  - b = p[r-2][c-1]
  - d = p[r-1][c-2]
  - e = p[r-1][c-1]
  - f = p[r-1][c]
  - h = p[r][c-1]
- State machine:
  - LLENANDO while row<2. Buffers and shift registers load, and win_valid stays 0.
  - LLENANDO → PROCESANDO on accepting (1, COLS-1).
  - PROCESANDO: a window is emitted for every accept with col≥2. Accepts with col<2 only prime the shift registers.
  - PROCESANDO → LLENANDO on accepting (ROWS-1, COLS-1).
- win_last is asserted with the window from (ROWS-1, COLS-1).
- No arithmetic on pixel data. Counters are $clog2(COLS) and $clog2(ROWS) bits wide.

## Timing
- Reset values:
  - b, d, e, f, h = 0; win_valid = 0; win_last = 0.
  - col = 0, row = 0, state LLENANDO.
  - Line buffer contents are not cleared. Fill masking makes stale data unobservable.
- Latency: window outputs are registered and appear one clock after the edge that accepts pixel (r,c).
- Throughput: one window per clock during sustained pix_valid in the interior region.
- pix_valid low:
  - win_valid = 0 the following cycle.
  - b..h hold their last values.
  - Counters, buffers and shift registers hold.
- Arbitrary gaps between pixels must produce a window stream identical to the gap-free case.
- Reset asserted mid-frame: the block immediately returns to reset values. The next accepted pixel is treated as (0,0) of a new frame, and no windows appear until row 2 col 2.
- win_valid and win_last drop to 0 after one cycle unless another qualifying accept occurs.

## Structure
- Shared package ventana_pkg:
  - Defaults COLS_DEF=512, ROWS_DEF=512, PIX_W_DEF=8.
  - State enum {LLENANDO, PROCESANDO}.
  - Window struct type {b, d, e, f, h}.
- One sub-module, linea_buffer: a parameterized COLS×PIX_W single-port RAM with read-before-write and an enable. It is instantiated twice.
- Counters, FSM and shift registers live in the top.

## Test plan
- Small frame, COLS=8, ROWS=5, pixel = 16·r + c, pix_valid held high:
  - First window is b=1, d=16, e=17, f=18, h=33.
  - Last window is b=38, d=53, e=54, f=55, h=70 with win_last=1.
  - Exactly 18 windows.
- Same frame with a pseudo-random pix_valid duty of about 40%:
  - Window sequence is identical to the previous test.
  - win_valid never asserted during gaps, and b..h stable during gaps.
- Two back-to-back frames (second frame = 255 − first frame values):
  - Windows 19–36 match the inverted frame.
  - No window mixes rows from both frames.
- rst pulsed after 20 pixels of frame one:
  - All outputs are 0 the next cycle.
  - The restarted frame produces the correct 18 windows, the first being b=1, d=16, e=17, f=18, h=33.
- Full 512×512 image loaded from the software image file:
  - 260100 windows, win_last on the final one.
  - Feeding the windows into the Laplacian filter gives output matching the software reference bit-for-bit.
